hls_run_sequencer: RTL and testbench

Synthesizable, parametrised run controller for an HLS-generated `main` core with N_CH slave memory channels. It replaces a file-driven single-run bench with a command-driven multi-run engine. Each run does an optional memory preload over the core's slave write ports, then a core reset pulse, a one-cycle start, and done detection with cycle counting and timeout. Each run ends with a status/cycle-count result record. It sits between the host/test controller and the core's start_port/done_port/S_* interface.

---
 rtl/hls_run_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_hls_run_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer.sv
// Command-driven run controller for an HLS core: optional slave-port preload,
// core reset pulse, one-cycle start, then done/timeout capture into a result record.
`timescale 1ns/1ps
module hls_run_sequencer #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int SIZE_W  = 7,
  parameter int CYC_W   = 32,
  parameter int TIMEOUT = 200000000,
  parameter int RST_CYC = 2,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_load,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [SIZE_W-1:0]        wr_size,
  input  logic                     wr_last,
  output logic                     dut_reset,
  output logic                     dut_start,
  input  logic                     dut_done,
  output logic [N_CH-1:0]          S_oe_ram,
  output logic [N_CH-1:0]          S_we_ram,
  output logic [N_CH*ADDR_W-1:0]   S_addr_ram,
  output logic [N_CH*DATA_W-1:0]   S_Wdata_ram,
  output logic [N_CH*SIZE_W-1:0]   S_data_ram_size,
  input  logic [N_CH-1:0]          Sout_DataRdy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_timeout,
  output logic [CYC_W-1:0]         res_cycles,
  output logic [15:0]              run_count
);

  localparam int RC_W = $clog2(RST_CYC + 1) + 1;
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_TMO = CYC_W'(TIMEOUT);
  localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_END  = RC_W'(RST_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRST   = 3'd2,
    S_START  = 3'd3,
    S_RUN    = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  state_t                  state_q;
  logic                    cmd_ready_q, wr_ready_q, dut_reset_q, dut_start_q, last_q;
  logic [N_CH-1:0]         we_q;
  logic [N_CH*ADDR_W-1:0]  addr_q;
  logic [N_CH*DATA_W-1:0]  wdata_q;
  logic [N_CH*SIZE_W-1:0]  size_q;
  logic [RC_W-1:0]         rst_cnt_q;
  logic [CYC_W-1:0]        cyc_q, res_cycles_q;
  logic                    res_valid_q, res_timeout_q;
  logic [15:0]             run_count_q;
  logic [N_CH-1:0]         wr_sel_s;
  logic                    beat_busy_s, beat_ack_s;

  // One-hot decode of the requested preload channel
  always_comb begin
    wr_sel_s = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      if (wr_ch == CH_W'(c)) wr_sel_s[c] = 1'b1;
      else                   wr_sel_s[c] = 1'b0;
    end
  end

  // Only DataRdy of the channel currently being written counts as an ack
  assign beat_busy_s = |we_q;
  assign beat_ack_s  = |(Sout_DataRdy & we_q);

  // Run sequencing FSM with all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      wr_ready_q    <= 1'b0;
      dut_reset_q   <= 1'b0;
      dut_start_q   <= 1'b0;
      last_q        <= 1'b0;
      we_q          <= {N_CH{1'b0}};
      addr_q        <= {(N_CH*ADDR_W){1'b0}};
      wdata_q       <= {(N_CH*DATA_W){1'b0}};
      size_q        <= {(N_CH*SIZE_W){1'b0}};
      rst_cnt_q     <= {RC_W{1'b0}};
      cyc_q         <= {CYC_W{1'b0}};
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_cycles_q  <= {CYC_W{1'b0}};
      run_count_q   <= 16'd0;
    end else begin
      wr_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          dut_reset_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_load) begin
              state_q <= S_LOAD;
            end else begin
              state_q     <= S_DRST;
              dut_reset_q <= 1'b0;
              rst_cnt_q   <= RC_ONE;
            end
          end
        end
        S_LOAD: begin
          if (beat_busy_s) begin
            if (beat_ack_s) begin
              we_q       <= {N_CH{1'b0}};
              addr_q     <= {(N_CH*ADDR_W){1'b0}};
              wdata_q    <= {(N_CH*DATA_W){1'b0}};
              size_q     <= {(N_CH*SIZE_W){1'b0}};
              wr_ready_q <= 1'b1;
              if (last_q) begin
                state_q     <= S_DRST;
                dut_reset_q <= 1'b0;
                rst_cnt_q   <= RC_ONE;
              end
            end
          end else if (wr_valid && !wr_ready_q) begin
            // The cycle right after an ack still shows the old beat, hence the wr_ready_q guard
            last_q <= wr_last;
            for (int c = 0; c < N_CH; c++) begin
              we_q[c]                       <= wr_sel_s[c];
              addr_q[c*ADDR_W +: ADDR_W]    <= wr_sel_s[c] ? wr_addr : {ADDR_W{1'b0}};
              wdata_q[c*DATA_W +: DATA_W]   <= wr_sel_s[c] ? wr_data : {DATA_W{1'b0}};
              size_q[c*SIZE_W +: SIZE_W]    <= wr_sel_s[c] ? wr_size : {SIZE_W{1'b0}};
            end
          end
        end
        S_DRST: begin
          if (rst_cnt_q >= RC_END) begin
            state_q     <= S_START;
            dut_reset_q <= 1'b1;
            dut_start_q <= 1'b1;
            cyc_q       <= CYC_ONE;
          end else begin
            rst_cnt_q <= rst_cnt_q + RC_ONE;
          end
        end
        S_START: begin
          dut_start_q <= 1'b0;
          if (dut_done) begin
            state_q       <= S_REPORT;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b0;
            res_cycles_q  <= CYC_ONE;
          end else if (CYC_TMO <= CYC_ONE) begin
            state_q       <= S_REPORT;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            res_cycles_q  <= CYC_TMO;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // cyc_q holds the count of cycles already elapsed; this cycle is cyc_q+1
          if (dut_done) begin
            state_q       <= S_REPORT;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b0;
            res_cycles_q  <= cyc_q + CYC_ONE;
          end else if (cyc_q + CYC_ONE >= CYC_TMO) begin
            state_q       <= S_REPORT;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            res_cycles_q  <= CYC_TMO;
          end else begin
            cyc_q <= cyc_q + CYC_ONE;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            run_count_q <= run_count_q + 16'd1;
            cmd_ready_q <= 1'b1;
            dut_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign wr_ready        = wr_ready_q;
  assign dut_reset       = dut_reset_q;
  assign dut_start       = dut_start_q;
  assign S_oe_ram        = {N_CH{1'b0}};
  assign S_we_ram        = we_q;
  assign S_addr_ram      = addr_q;
  assign S_Wdata_ram     = wdata_q;
  assign S_data_ram_size = size_q;
  assign res_valid       = res_valid_q;
  assign res_timeout     = res_timeout_q;
  assign res_cycles      = res_cycles_q;
  assign run_count       = run_count_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed + randomized bench for hls_run_sequencer; results are predicted from
// the done delay alone (cycles = min(delay+1, TIMEOUT)).
`timescale 1ns/1ps
module tb_hls_run_sequencer;
  localparam int TMO = 50;
  localparam int RSTC = 2;

  logic         clock, reset;
  logic         cmd_valid, cmd_ready, cmd_load;
  logic         wr_valid, wr_ready, wr_last;
  logic [0:0]   wr_ch;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [6:0]   wr_size;
  logic         dut_reset, dut_start, dut_done;
  logic [1:0]   S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [19:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic         res_valid, res_ready, res_timeout;
  logic [31:0]  res_cycles;
  logic [15:0]  run_count;

  int total = 0;
  int bad = 0;
  int exp_runs = 0;
  int wr_pulses = 0;

  hls_run_sequencer #(.N_CH(2), .ADDR_W(10), .DATA_W(64), .SIZE_W(7), .CYC_W(32),
                      .TIMEOUT(TMO), .RST_CYC(RSTC)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size), .wr_last(wr_last),
    .dut_reset(dut_reset), .dut_start(dut_start), .dut_done(dut_done),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_DataRdy(Sout_DataRdy), .res_valid(res_valid), .res_ready(res_ready),
    .res_timeout(res_timeout), .res_cycles(res_cycles), .run_count(run_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (wr_ready === 1'b1) wr_pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_beat(input logic ch, input logic [9:0] a, input logic [63:0] d,
                         input logic [6:0] sz, input logic last);
    logic [1:0]   oh;
    logic [19:0]  ea;
    logic [127:0] ed;
    logic [13:0]  es;
    int n;
    oh = 2'b01 << ch;
    ea = '0; ea[ch*10 +: 10] = a;
    ed = '0; ed[ch*64 +: 64] = d;
    es = '0; es[ch*7 +: 7] = sz;
    wr_ch = ch; wr_addr = a; wr_data = d; wr_size = sz; wr_last = last; wr_valid = 1'b1;
    n = 0;
    while (S_we_ram == 2'b00 && n < 8) begin tick(); n++; end
    chk("beat_we", S_we_ram, oh);
    chk("beat_addr", S_addr_ram, ea);
    chk("beat_data", S_Wdata_ram, ed);
    chk("beat_size", S_data_ram_size, es);
    Sout_DataRdy = ~oh;
    tick();
    chk("beat_hold_we", S_we_ram, oh);
    chk("beat_no_early_ack", wr_ready, 1'b0);
    Sout_DataRdy = oh;
    tick();
    chk("beat_ack", wr_ready, 1'b1);
    chk("beat_we_drop", S_we_ram, 2'b00);
    Sout_DataRdy = 2'b00;
    wr_valid = 1'b0;
  endtask

  task automatic do_run(input bit load, input int nbeats, input bit spec_beats,
                        input int d, input bit has_done, input int hold);
    int n;
    int p0;
    logic [31:0] ecyc;
    logic eto;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_load = load;
    tick();
    cmd_valid = 1'b0; cmd_load = 1'b0;
    chk("cmd_taken", cmd_ready, 1'b0);
    p0 = wr_pulses;
    if (load) begin
      if (spec_beats) begin
        do_beat(1'b0, 10'h010, {$urandom, $urandom}, 7'd64, 1'b0);
        do_beat(1'b1, 10'h3FF, {$urandom, $urandom}, 7'd32, 1'b0);
        do_beat(1'b0, 10'h011, {$urandom, $urandom}, 7'd64, 1'b1);
      end else begin
        for (int b = 0; b < nbeats; b++)
          do_beat(1'($urandom_range(0, 1)), 10'($urandom), {$urandom, $urandom},
                  7'($urandom_range(1, 64)), (b == nbeats - 1));
      end
    end
    // Core reset must be low exactly RSTC cycles, then a single start pulse
    n = 0;
    while (dut_reset !== 1'b0 && n < 10) begin tick(); n++; end
    n = 0;
    while (dut_reset === 1'b0 && n < 10) begin
      chk("drst_no_start", dut_start, 1'b0);
      tick(); n++;
    end
    chk("drst_len", n, RSTC);
    chk("start_pulse", dut_start, 1'b1);
    if (load) chk("wr_ready_pulses", wr_pulses - p0, spec_beats ? 3 : nbeats);
    if (has_done && d == 0) dut_done = 1'b1;
    tick();
    dut_done = 1'b0;
    chk("start_fall", dut_start, 1'b0);
    if (has_done && d > 0) begin
      for (int i = 1; i < d; i++) tick();
      dut_done = 1'b1;
      tick();
      dut_done = 1'b0;
    end
    if (has_done && (d + 1) <= TMO) begin ecyc = 32'(d + 1); eto = 1'b0; end
    else begin ecyc = 32'(TMO); eto = 1'b1; end
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin tick(); n++; end
    chk("res_valid", res_valid, 1'b1);
    chk("res_cycles", res_cycles, ecyc);
    chk("res_timeout", res_timeout, eto);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_cycles", res_cycles, ecyc);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_run_count", run_count, 16'(exp_runs));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_runs++;
    chk("res_valid_clr", res_valid, 1'b0);
    chk("run_count", run_count, 16'(exp_runs));
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; wr_valid = 1'b0; wr_ch = 1'b0;
    wr_addr = '0; wr_data = '0; wr_size = '0; wr_last = 1'b0; dut_done = 1'b0;
    Sout_DataRdy = 2'b00; res_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_dut_reset", dut_reset, 1'b0);
    chk("rst_we", S_we_ram, 2'b00);
    chk("rst_oe", S_oe_ram, 2'b00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_run_count", run_count, 16'd0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_dut_reset", dut_reset, 1'b1);

    // Reset asserted while channel 1 is mid-write
    cmd_valid = 1'b1; cmd_load = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_load = 1'b0;
    wr_ch = 1'b1; wr_addr = 10'h155; wr_data = 64'hDEAD_BEEF_0123_4567; wr_size = 7'd64;
    wr_last = 1'b0; wr_valid = 1'b1;
    tick();
    chk("midload_we", S_we_ram, 2'b10);
    reset = 1'b1;
    #1;
    chk("abort_we", S_we_ram, 2'b00);
    chk("abort_addr", S_addr_ram, 20'd0);
    chk("abort_data", S_Wdata_ram, 128'd0);
    chk("abort_dut_reset", dut_reset, 1'b0);
    chk("abort_res_valid", res_valid, 1'b0);
    chk("abort_run_count", run_count, 16'd0);
    wr_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("abort_idle", cmd_ready, 1'b1);
    chk("abort_no_res", res_valid, 1'b0);

    do_run(1'b1, 3, 1'b1, 9, 1'b1, 1);    // preload, done 9 after start -> 10
    do_run(1'b0, 0, 1'b0, 0, 1'b1, 0);    // done in start cycle -> 1
    do_run(1'b0, 0, 1'b0, $urandom_range(1, 40), 1'b1, 0);
    do_run(1'b0, 0, 1'b0, $urandom_range(1, 40), 1'b1, 0);
    do_run(1'b0, 0, 1'b0, 0, 1'b0, 0);    // no done -> timeout
    do_run(1'b0, 0, 1'b0, TMO - 1, 1'b1, 0); // done coincides with timeout
    do_run(1'b0, 0, 1'b0, $urandom_range(1, 20), 1'b1, 20);
    for (int r = 0; r < 5; r++)
      do_run(1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0,
             $urandom_range(0, 60), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
